// File: rtl/ascon_permutation_ctrl.sv
// Iterative Ascon-p[rnd] engine: one full round (constant, S-box, linear layer)
// per clock on a 320-bit state, with a start/ready/done handshake.
package ascon_pkg;
  typedef logic [4:0][63:0] ascon_state_t;
  typedef logic [3:0]       rnd_t;
endpackage

module constant_addition_layer
  import ascon_pkg::*;
(
  input  ascon_state_t state_array_i,
  input  logic         round_config_i,
  input  rnd_t         rnd_i,
  output ascon_state_t state_array_o
);

  rnd_t       idx;
  logic [7:0] rc;

  // p8 uses the last eight of the twelve p12 constants
  always_comb begin
    idx = round_config_i ? rnd_i : rnd_i + 4'd4;
    case (idx)
      4'd0:    rc = 8'hf0;
      4'd1:    rc = 8'he1;
      4'd2:    rc = 8'hd2;
      4'd3:    rc = 8'hc3;
      4'd4:    rc = 8'hb4;
      4'd5:    rc = 8'ha5;
      4'd6:    rc = 8'h96;
      4'd7:    rc = 8'h87;
      4'd8:    rc = 8'h78;
      4'd9:    rc = 8'h69;
      4'd10:   rc = 8'h5a;
      4'd11:   rc = 8'h4b;
      default: rc = 8'h00;
    endcase
    state_array_o    = state_array_i;
    state_array_o[2] = state_array_i[2] ^ {56'd0, rc};
  end

endmodule

module ascon_permutation_ctrl
  import ascon_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         round_config_i,
  input  ascon_state_t state_array_i,
  output logic         ready_o,
  output logic         done_o,
  output rnd_t         rnd_o,
  output ascon_state_t state_array_o
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm_q, fsm_d;
  ascon_state_t state_q, state_d;
  logic         cfg_q, cfg_d;
  rnd_t         rnd_q, rnd_d;
  logic         done_q, done_d;

  ascon_state_t c_state;
  ascon_state_t s_state;
  ascon_state_t l_state;
  logic [63:0]  x [5];
  logic [63:0]  t [5];
  logic         last_round;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  constant_addition_layer u_cadd (
    .state_array_i  (state_q),
    .round_config_i (cfg_q),
    .rnd_i          (rnd_q),
    .state_array_o  (c_state)
  );

  // Bitsliced S-box: each of the 64 columns is one 5-bit substitution
  always_comb begin
    for (int i = 0; i < 5; i++) x[i] = c_state[i];
    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
    for (int i = 0; i < 5; i++) x[i] = x[i] ^ t[(i + 1) % 5];
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];
    for (int i = 0; i < 5; i++) s_state[i] = x[i];
  end

  always_comb begin
    l_state[0] = s_state[0] ^ ror(s_state[0], 19) ^ ror(s_state[0], 28);
    l_state[1] = s_state[1] ^ ror(s_state[1], 61) ^ ror(s_state[1], 39);
    l_state[2] = s_state[2] ^ ror(s_state[2], 1)  ^ ror(s_state[2], 6);
    l_state[3] = s_state[3] ^ ror(s_state[3], 10) ^ ror(s_state[3], 17);
    l_state[4] = s_state[4] ^ ror(s_state[4], 7)  ^ ror(s_state[4], 41);
  end

  assign last_round = cfg_q ? (rnd_q == 4'd11) : (rnd_q == 4'd7);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cfg_d   = cfg_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d = state_array_i;
          cfg_d   = round_config_i;
          rnd_d   = 4'd0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = l_state;
        rnd_d   = rnd_q + 4'd1;
        if (last_round) begin
          fsm_d  = IDLE;
          rnd_d  = 4'd0;
          done_d = 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cfg_q   <= 1'b0;
      rnd_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cfg_q   <= cfg_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  assign ready_o       = (fsm_q == IDLE);
  assign done_o        = done_q;
  assign rnd_o         = rnd_q;
  assign state_array_o = state_q;

endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// Scoreboard bench for ascon_permutation_ctrl using a table-driven Ascon model.
module tb_ascon_permutation_ctrl;
  import ascon_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic         round_config_i;
  ascon_state_t state_array_i;
  logic         ready_o;
  logic         done_o;
  rnd_t         rnd_o;
  ascon_state_t state_array_o;

  typedef struct {
    ascon_state_t st;
    logic         cfg;
    int           acc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   lastDone = -1;
  bit   b2bMode = 1'b0;

  logic [4:0] sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                            5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                            5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                            5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  always #5 clk = ~clk;

  ascon_permutation_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .round_config_i (round_config_i),
    .state_array_i  (state_array_i),
    .ready_o        (ready_o),
    .done_o         (done_o),
    .rnd_o          (rnd_o),
    .state_array_o  (state_array_o)
  );

  task automatic checkOutput(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference uses the S-box lookup table rather than the bitsliced equations
  function automatic ascon_state_t modelPerm(input ascon_state_t s, input logic p12);
    ascon_state_t x;
    ascon_state_t y;
    logic [4:0]   col;
    logic [4:0]   o;
    logic [3:0]   idx;
    int           nr;
    x  = s;
    nr = p12 ? 12 : 8;
    for (int r = 0; r < nr; r++) begin
      idx = 4'(r + 12 - nr);
      x[2][7:0] = x[2][7:0] ^ {4'hf - idx, idx};
      for (int j = 0; j < 64; j++) begin
        col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        o = sbox[col];
        y[0][j] = o[4];
        y[1][j] = o[3];
        y[2][j] = o[2];
        y[3][j] = o[1];
        y[4][j] = o[0];
      end
      x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
      x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
      x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
      x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
      x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
    end
    return x;
  endfunction

  function automatic ascon_state_t randState();
    ascon_state_t s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  // Push the expected result at the edge where the DUT accepts a request
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rst_n && ready_o && start_i)
      expQ.push_back('{st: modelPerm(state_array_i, round_config_i),
                       cfg: round_config_i, acc: cycle + 1});
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    int   n;
    if (rst_n) begin
      if (done_o) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_done", 1, 0);
        end else begin
          e = expQ.pop_front();
          n = e.cfg ? 12 : 8;
          checkOutput("result", state_array_o, e.st);
          checkOutput("latency", cycle - e.acc, n);
          checkOutput("rnd_at_done", rnd_o, 0);
          checkOutput("ready_at_done", ready_o, 1);
          if (b2bMode && lastDone >= 0) checkOutput("spacing", cycle - lastDone, n + 1);
          lastDone = cycle;
        end
      end else if (!ready_o && expQ.size() > 0) begin
        checkOutput("rnd_seq", rnd_o, cycle - expQ[0].acc);
        if (!expQ[0].cfg && rnd_o == 4'd0)
          checkOutput("p8_rc_rnd0", dut.c_state[2] ^ dut.state_q[2], 64'hb4);
        if (!expQ[0].cfg && rnd_o == 4'd7)
          checkOutput("p8_rc_rnd7", dut.c_state[2] ^ dut.state_q[2], 64'h4b);
      end
    end
  end

  task automatic applyStimulus(input ascon_state_t s, input logic cfg);
    int g;
    g = 0;
    @(negedge clk);
    while (!ready_o && g < 50) begin
      @(negedge clk);
      g++;
    end
    state_array_i  = s;
    round_config_i = cfg;
    start_i        = 1'b1;
    @(negedge clk);
    start_i        = 1'b0;
  endtask

  task automatic waitDone();
    int g;
    g = 0;
    while (expQ.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (expQ.size() != 0) checkOutput("timeout", expQ.size(), 0);
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, ready_o, 1);
    checkOutput({tag, "_done"}, done_o, 0);
    checkOutput({tag, "_rnd"}, rnd_o, 0);
    checkOutput({tag, "_state"}, state_array_o, '0);
  endtask

  initial begin
    ascon_state_t s;
    ascon_state_t r;
    int           g;

    rst_n          = 1'b0;
    start_i        = 1'b1;
    round_config_i = 1'b1;
    state_array_i  = randState();
    #1;
    checkResetOutputs("reset");
    repeat (3) @(negedge clk);
    checkResetOutputs("reset_hold");
    start_i = 1'b0;
    rst_n   = 1'b1;
    checkOutput("reset_no_accept", expQ.size(), 0);

    $display("[TB] p12 on zero state");
    applyStimulus('0, 1'b1);
    waitDone();

    $display("[TB] p8 on random state");
    s = randState();
    r = modelPerm(s, 1'b0);
    applyStimulus(s, 1'b0);
    waitDone();
    repeat (3) @(negedge clk);
    checkOutput("idle_hold", state_array_o, r);

    $display("[TB] start ignored while busy");
    applyStimulus(randState(), 1'b1);
    repeat (2) @(negedge clk);
    state_array_i  = randState();
    round_config_i = 1'b0;
    start_i        = 1'b1;
    @(negedge clk);
    start_i        = 1'b0;
    waitDone();
    repeat (15) @(negedge clk);

    $display("[TB] back-to-back starts");
    lastDone = -1;
    b2bMode  = 1'b1;
    start_i  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      state_array_i  = randState();
      round_config_i = 1'($urandom_range(0, 1));
      g = 0;
      while (!ready_o && g < 50) begin
        @(negedge clk);
        g++;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    waitDone();
    b2bMode = 1'b0;

    $display("[TB] abort mid-run");
    applyStimulus(randState(), 1'b1);
    g = 0;
    while (rnd_o != 4'd5 && g < 50) begin
      @(negedge clk);
      g++;
    end
    checkOutput("abort_reach_rnd5", rnd_o, 5);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("abort");
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    applyStimulus(randState(), 1'b0);
    waitDone();

    checkOutput("queue_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
